ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes id_ex outputs, produces ALU result, store data and branch/jump redirect for ex_mem.
//  Single-cycle ALU plus iterative multiply/divide; asserts ex_busy to freeze if_id/id_ex/pc during mul/div.
//  Operand forwarding muxes (select from forwarding unit) live here.
// PARAMETERS
//  XLEN      32  datapath width
//  MD_STEPS  32  mul/div iterations, one bit per cycle; equals XLEN
// PORTS
//  clk           in   1     clock
//  reset         in   1     async, active-high
//  pc_in         in   32    instruction PC from id_ex
//  rs1_data_in   in   32    rs1 value from id_ex
//  rs2_data_in   in   32    rs2 value from id_ex
//  imm_in        in   32    immediate from id_ex
//  alu_op_in     in   4     operation code, see BEHAVIOUR
//  alu_src_in    in   1     1: B operand = imm; 0: B = forwarded rs2
//  branch_in     in   1     conditional branch
//  br_inv_in     in   1     invert branch condition (BGE/BGEU/BNE forms)
//  jump_in       in   1     JAL (alu_src=0) / JALR (alu_src=1)
//  fwd_a_sel     in   2     0 id_ex rs1, 1 exmem_result, 2 wb_result, 3 reserved (=0)
//  fwd_b_sel     in   2     same encoding for rs2
//  exmem_result  in   32    forwarded value from ex_mem
//  wb_result     in   32    forwarded value from write-back
//  ex_hold       in   1     downstream stall; mul/div holds result
//  ex_kill       in   1     squash current op; aborts mul/div
//  alu_result    out  32    result to ex_mem
//  store_data    out  32    forwarded rs2 to ex_mem
//  redirect      out  1     branch taken or jump
//  redirect_pc   out  32    target PC
//  ex_busy       out  1     mul/div result not ready; stall upstream
// BEHAVIOUR
//  Reset: FSM IDLE, mul/div regs 0; id_ex zeroed -> alu_result 0, redirect 0, ex_busy 0.
//  Encoding: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//            10 MUL 11 MULHU 12 DIV 13 DIVU 14 REM 15 REMU. LUI = ADD with rs1=x0.
//  Shifts use B[4:0]. SLT/SLTU result 0 or 1. ALU ops 0-9 combinational, zero latency.
//  Branch (branch_in=1): cond = SUB:A==B, SLT:A<s B, SLTU:A<u B; taken = cond^br_inv_in;
//    redirect_pc = pc_in+imm_in. Any other alu_op with branch_in: not taken.
//  Jump: redirect=1; JAL pc_in+imm_in; JALR (A+imm_in)&~1; alu_result = pc_in+4.
//  ex_kill=1: redirect=0, ex_busy=0 same cycle.
//  Mul/div FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: op 10-15 and !ex_kill -> latch |A|,|B|, signs, op; ex_busy=1; -> RUN.
//   RUN: MD_STEPS cycles, ex_busy=1; shift-add multiply / restoring divide, 1 bit/cycle.
//   DONE: sign correction applied; alu_result valid, ex_busy=0; ex_hold=1 stays DONE, else -> IDLE.
//   Latency: op enters cycle 0; result in cycle MD_STEPS+1 (33); next op starts in IDLE after.
//  Div by zero: DIV/DIVU quotient all ones; REM/REMU = dividend. Same latency.
//  Overflow DIV -2^31/-1: quotient -2^31, REM 0. MUL low 32 bits; MULHU unsigned high 32 bits.
//  ex_kill during RUN/DONE -> IDLE next cycle, result discarded. Reset mid-op -> IDLE immediately.
//  Non-muldiv op present in IDLE: FSM stays IDLE, ex_busy=0.
// STRUCTURE
//  Package ex_pkg: alu_op localparams (ALU_ADD..ALU_REMU), fwd select codes, md_state_t enum.
//  Sub-module muldiv_iter: FSM + shift registers; ports start, kill, hold, op, a, b -> busy, done, result.
//  ALU, forwarding muxes, branch/jump target logic inline in ex_stage.
// TESTING
//  ADD 5+7 -> 12; SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000>>4 -> 0xF8000000; SLTU 1,0xFFFFFFFF -> 1.
//  fwd_a_sel=1, exmem_result=0x10, ADD imm 4 -> 0x14; fwd_b_sel=2 -> store_data = wb_result.
//  BEQ A=B=9, pc 0x100, imm 0x20 -> redirect=1, 0x120; br_inv=1 -> redirect=0; JALR A=0x203 imm 0 -> 0x202, result pc+4.
//  DIV -7/2 -> ex_busy high cycles 0-32, cycle 33 result -3; REM -> -1; DIVU x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
//  MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same -> 1; ex_hold 3 cycles in DONE -> result held, ex_busy 0.
//  ex_kill at RUN cycle 10 -> IDLE next, ex_busy 0; reset at RUN cycle 5 -> IDLE, ex_busy 0; back-to-back DIVs both correct.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forwarding selects,
// and the multiply/divide sequencer state type.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MULHU = 4'd11;
  localparam logic [3:0] ALU_DIV   = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_REM   = 4'd14;
  localparam logic [3:0] ALU_REMU  = 4'd15;

  localparam logic [1:0] FWD_IDEX  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;
  localparam logic [1:0] FWD_RSVD  = 2'd3;

  typedef enum logic [1:0] {MdIdle, MdRun, MdDone} md_state_t;

  // Codes 10..15 are the iterative multiply/divide group.
  function automatic logic is_md_op(logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on magnitudes, sign fix-up applied when the result is read.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MD_STEPS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic            hold,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(MD_STEPS);

  md_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] acc_q;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] opnd_q;  // multiplicand / divisor
  logic [3:0]      op_q;
  logic            mul_q, q_neg_q, r_neg_q;

  logic            start_mul, start_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, div_diff;
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;

  assign start_mul    = (op == ALU_MUL) | (op == ALU_MULHU);
  assign start_signed = (op == ALU_DIV) | (op == ALU_REM);
  assign a_neg        = start_signed & a[XLEN-1];
  assign b_neg        = start_signed & b[XLEN-1];
  assign a_abs        = a_neg ? -a : a;
  assign b_abs        = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  // Remainder stays below the divisor, so the low XLEN bits hold the full difference.
  assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

  // Sequencer: latch operands, iterate MD_STEPS times, hold result until released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= ALU_ADD;
      mul_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      unique case (state_q)
        MdIdle: begin
          if (start && !kill) begin
            state_q <= MdRun;
            cnt_q   <= '0;
            op_q    <= op;
            mul_q   <= start_mul;
            acc_q   <= '0;
            lo_q    <= start_mul ? b : a_abs;
            opnd_q  <= start_mul ? a : b_abs;
            // Divide by zero returns all ones regardless of signs.
            q_neg_q <= (a_neg ^ b_neg) & (b != '0);
            r_neg_q <= a_neg;
          end
        end
        MdRun: begin
          if (kill) begin
            state_q <= MdIdle;
          end else begin
            if (mul_q) begin
              acc_q <= mul_sum[XLEN:1];
              lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
            end else begin
              acc_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
              lo_q  <= {lo_q[XLEN-2:0], div_ge};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(MD_STEPS - 1)) state_q <= MdDone;
          end
        end
        MdDone: begin
          if (kill || !hold) state_q <= MdIdle;
        end
        default: state_q <= MdIdle;
      endcase
    end
  end

  // Busy covers the issue cycle and every iteration; a kill drops it at once.
  always_comb begin
    busy = !kill && (((state_q == MdIdle) && start) || (state_q == MdRun));
    done = (state_q == MdDone);
  end

  // Result select with sign correction of the magnitude result.
  always_comb begin
    result = '0;
    case (op_q)
      ALU_MUL:           result = lo_q;
      ALU_MULHU:         result = acc_q;
      ALU_DIV, ALU_DIVU: result = q_neg_q ? -lo_q : lo_q;
      default:           result = r_neg_q ? -acc_q : acc_q;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution,
// and the iterative multiply/divide unit that stalls upstream while busy.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MD_STEPS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [3:0]      alu_op_in,
  input  logic            alu_src_in,
  input  logic            branch_in,
  input  logic            br_inv_in,
  input  logic            jump_in,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_hold,
  input  logic            ex_kill,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_busy
);

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_out, md_result, br_target;
  logic            br_cond, br_valid, md_busy, md_done, md_op;

  // Forwarding muxes; the reserved select yields zero.
  always_comb begin
    case (fwd_a_sel)
      FWD_IDEX:  op_a = rs1_data_in;
      FWD_EXMEM: op_a = exmem_result;
      FWD_WB:    op_a = wb_result;
      default:   op_a = '0;
    endcase
    case (fwd_b_sel)
      FWD_IDEX:  rs2_fwd = rs2_data_in;
      FWD_EXMEM: rs2_fwd = exmem_result;
      FWD_WB:    rs2_fwd = wb_result;
      default:   rs2_fwd = '0;
    endcase
  end

  assign op_b       = alu_src_in ? imm_in : rs2_fwd;
  assign store_data = rs2_fwd;
  assign md_op      = is_md_op(alu_op_in);

  // Single-cycle ALU for codes 0..9.
  always_comb begin
    alu_out = '0;
    case (alu_op_in)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SLL:  alu_out = op_a << op_b[4:0];
      ALU_SRL:  alu_out = op_a >> op_b[4:0];
      ALU_SRA:  alu_out = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  alu_out = '0;
    endcase
  end

  // Branch condition; only SUB/SLT/SLTU encode a compare.
  always_comb begin
    br_cond  = 1'b0;
    br_valid = 1'b1;
    case (alu_op_in)
      ALU_SUB:  br_cond = (op_a == op_b);
      ALU_SLT:  br_cond = $signed(op_a) < $signed(op_b);
      ALU_SLTU: br_cond = (op_a < op_b);
      default:  br_valid = 1'b0;
    endcase
  end

  // Redirect target and result muxing; JALR clears bit 0.
  always_comb begin
    br_target   = pc_in + imm_in;
    redirect_pc = (jump_in && alu_src_in) ? ((op_a + imm_in) & ~XLEN'(1)) : br_target;
    redirect    = !ex_kill && (jump_in || (branch_in && br_valid && (br_cond ^ br_inv_in)));
    if (jump_in)    alu_result = pc_in + XLEN'(4);
    else if (md_op) alu_result = md_done ? md_result : '0;
    else            alu_result = alu_out;
  end

  assign ex_busy = md_busy;

  muldiv_iter #(
    .XLEN     (XLEN),
    .MD_STEPS (MD_STEPS)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_op),
    .kill   (ex_kill),
    .hold   (ex_hold),
    .op     (alu_op_in),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

endmodule
